// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receive frame checker: FSM states and parity-mode encodings.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  // Expected parity bit for a mode, given the XOR of all data bits.
  function automatic logic exp_parity(input logic [1:0] typ, input logic data_xor);
    case (typ)
      PAR_EVEN: return data_xor;
      PAR_ODD:  return ~data_xor;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/rx_frame_check.sv
// UART receive framing checker: assembles data from sample pulses, checks start,
// parity and stop bits, and keeps saturating parity/framing error counts.
module rx_frame_check
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  frame_start,
  input  logic                  sample_valid,
  input  logic                  sampled_bit,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_TYP,
  input  logic                  STOP2,
  input  logic                  clr_counts,
  output logic [DATA_WIDTH-1:0] P_Data,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error,
  output logic                  start_error,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  parity_err_cnt,
  output logic [CNT_WIDTH-1:0]  frame_err_cnt
);

  localparam int unsigned BitCntW = $clog2(DATA_WIDTH);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);

  rx_state_e             state_q, state_d;
  logic                  par_en_q, par_en_d;
  logic [1:0]            par_typ_q, par_typ_d;
  logic                  stop2_q, stop2_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic                  xor_q, xor_d;
  logic                  par_flag_q, par_flag_d;
  logic                  stop_flag_q, stop_flag_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  parity_error_q, parity_error_d;
  logic                  stop_error_q, stop_error_d;
  logic                  start_error_q, start_error_d;
  logic                  busy_q, busy_d;

  always_comb begin
    state_d        = state_q;
    par_en_d       = par_en_q;
    par_typ_d      = par_typ_q;
    stop2_d        = stop2_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    xor_d          = xor_q;
    par_flag_d     = par_flag_q;
    stop_flag_d    = stop_flag_q;
    stop_cnt_d     = stop_cnt_q;
    p_data_d       = p_data_q;
    data_valid_d   = 1'b0;
    parity_error_d = 1'b0;
    stop_error_d   = 1'b0;
    start_error_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A coincident sample_valid belongs to no frame yet and is dropped.
        if (frame_start) begin
          state_d     = StStart;
          par_en_d    = PAR_EN;
          par_typ_d   = PAR_TYP;
          stop2_d     = STOP2;
          bit_cnt_d   = '0;
          xor_d       = 1'b0;
          par_flag_d  = 1'b0;
          stop_flag_d = 1'b0;
          stop_cnt_d  = 1'b0;
        end
      end
      StStart: begin
        if (sample_valid) begin
          if (sampled_bit) begin
            start_error_d = 1'b1;
            state_d       = StIdle;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (sample_valid) begin
          shift_d   = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          xor_d     = xor_q ^ sampled_bit;
          bit_cnt_d = bit_cnt_q + BitCntW'(1);
          if (bit_cnt_q == LastBit) begin
            state_d = par_en_q ? StParity : StStop;
          end
        end
      end
      StParity: begin
        if (sample_valid) begin
          par_flag_d = (sampled_bit != exp_parity(par_typ_q, xor_q));
          state_d    = StStop;
        end
      end
      StStop: begin
        if (sample_valid) begin
          stop_flag_d = stop_flag_q | ~sampled_bit;
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            state_d        = StIdle;
            p_data_d       = shift_q;
            data_valid_d   = !par_flag_q && !stop_flag_d;
            parity_error_d = par_flag_q;
            stop_error_d   = stop_flag_d;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= StIdle;
      par_en_q       <= 1'b0;
      par_typ_q      <= 2'b00;
      stop2_q        <= 1'b0;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      xor_q          <= 1'b0;
      par_flag_q     <= 1'b0;
      stop_flag_q    <= 1'b0;
      stop_cnt_q     <= 1'b0;
      p_data_q       <= '0;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
      start_error_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      par_en_q       <= par_en_d;
      par_typ_q      <= par_typ_d;
      stop2_q        <= stop2_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      xor_q          <= xor_d;
      par_flag_q     <= par_flag_d;
      stop_flag_q    <= stop_flag_d;
      stop_cnt_q     <= stop_cnt_d;
      p_data_q       <= p_data_d;
      data_valid_q   <= data_valid_d;
      parity_error_q <= parity_error_d;
      stop_error_q   <= stop_error_d;
      start_error_q  <= start_error_d;
      busy_q         <= busy_d;
    end
  end

  // Counters take the registered pulses, so they move one cycle after the pulse.
  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_par_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .inc  (parity_error_q),
    .clr  (clr_counts),
    .count(parity_err_cnt)
  );

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_frm_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .inc  (stop_error_q | start_error_q),
    .clr  (clr_counts),
    .count(frame_err_cnt)
  );

  assign P_Data       = p_data_q;
  assign data_valid   = data_valid_q;
  assign parity_error = parity_error_q;
  assign stop_error   = stop_error_q;
  assign start_error  = start_error_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_rx_frame_check.sv
// Self-checking bench for rx_frame_check: directed frames plus randomized frames
// scored against a frame-level reference model.
module tb_rx_frame_check;

  localparam int unsigned DW     = 8;
  localparam int unsigned CW     = 2;
  localparam int          CntMax = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic          frame_start, sample_valid, sampled_bit;
  logic          PAR_EN, STOP2, clr_counts;
  logic [1:0]    PAR_TYP;
  logic [DW-1:0] P_Data;
  logic          data_valid, parity_error, stop_error, start_error, busy;
  logic [CW-1:0] parity_err_cnt, frame_err_cnt;
  logic [4:0]    outs;

  assign outs = {data_valid, parity_error, stop_error, start_error, busy};

  rx_frame_check #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) u_dut (
    .CLK           (CLK),
    .RST           (RST),
    .frame_start   (frame_start),
    .sample_valid  (sample_valid),
    .sampled_bit   (sampled_bit),
    .PAR_EN        (PAR_EN),
    .PAR_TYP       (PAR_TYP),
    .STOP2         (STOP2),
    .clr_counts    (clr_counts),
    .P_Data        (P_Data),
    .data_valid    (data_valid),
    .parity_error  (parity_error),
    .stop_error    (stop_error),
    .start_error   (start_error),
    .busy          (busy),
    .parity_err_cnt(parity_err_cnt),
    .frame_err_cnt (frame_err_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          par_en;
    logic [1:0]    typ;
    logic          stop2;
    logic          start_bit;
    logic          par_bit;
    logic          stop0;
    logic          stop1;
  } frame_t;

  int            checks = 0;
  int            errors = 0;
  int            exp_pcnt = 0;
  int            exp_fcnt = 0;
  logic [DW-1:0] exp_pdata = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Parity bit a correct transmitter would send for this mode.
  function automatic logic model_parity(input logic [1:0] typ, input logic [DW-1:0] d);
    int ones = $countones(d);
    case (typ)
      2'b00:   return ((ones % 2) == 1);
      2'b01:   return ((ones % 2) == 0);
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int sat_inc(input int v);
    return (v < CntMax) ? v + 1 : v;
  endfunction

  function automatic frame_t mk(input logic [DW-1:0] data, input logic en, input logic [1:0] typ,
                                input logic s2, input logic sb, input logic pb,
                                input logic st0, input logic st1);
    frame_t f;
    f.data = data; f.par_en = en; f.typ = typ; f.stop2 = s2;
    f.start_bit = sb; f.par_bit = pb; f.stop0 = st0; f.stop1 = st1;
    return f;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    f.data      = DW'($urandom);
    f.par_en    = 1'($urandom);
    f.typ       = 2'($urandom);
    f.stop2     = 1'($urandom);
    f.start_bit = ($urandom_range(0, 9) == 0);
    f.par_bit   = model_parity(f.typ, f.data) ^ ($urandom_range(0, 3) == 0);
    f.stop0     = ($urandom_range(0, 5) != 0);
    f.stop1     = ($urandom_range(0, 5) != 0);
    return f;
  endfunction

  task automatic check_counts(input string tag);
    check_eq({tag, "_par_cnt"}, 32'(parity_err_cnt), 32'(exp_pcnt));
    check_eq({tag, "_frm_cnt"}, 32'(frame_err_cnt), 32'(exp_fcnt));
  endtask

  // Random idle gap before each sample; stray frame_start pulses there must be ignored.
  task automatic sample_bit(input logic b);
    int gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++) begin
      frame_start = ($urandom_range(0, 7) == 0);
      @(negedge CLK);
      frame_start = 1'b0;
    end
    sample_valid = 1'b1;
    sampled_bit  = b;
    @(negedge CLK);
    sample_valid = 1'b0;
    sampled_bit  = 1'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      sample_valid = ($urandom_range(0, 3) == 0);
      sampled_bit  = 1'($urandom);
      @(negedge CLK);
      clr_counts = 1'b0;
    end
    sample_valid = 1'b0;
  endtask

  task automatic begin_frame(input frame_t f);
    frame_start  = 1'b1;
    PAR_EN       = f.par_en;
    PAR_TYP      = f.typ;
    STOP2        = f.stop2;
    sample_valid = ($urandom_range(0, 3) == 0);
    sampled_bit  = 1'($urandom);
    @(negedge CLK);
    frame_start  = 1'b0;
    sample_valid = 1'b0;
    clr_counts   = 1'b0;
    PAR_EN       = 1'($urandom);
    PAR_TYP      = 2'($urandom);
    STOP2        = 1'($urandom);
    check_eq("accept", 32'(outs), 32'(5'b00001));
    check_counts("pre");
  endtask

  // Runs one frame; returns at the cycle its result pulses are visible.
  task automatic do_frame(input frame_t f, input bit clr_at_end);
    logic par_bad, stop_bad, last_stop;
    begin_frame(f);
    sample_bit(f.start_bit);
    if (f.start_bit) begin
      exp_fcnt = sat_inc(exp_fcnt);
      check_eq("start_glitch", 32'(outs), 32'(5'b00010));
      check_eq("glitch_pdata", 32'(P_Data), 32'(exp_pdata));
    end else begin
      for (int i = 0; i < DW; i++) sample_bit(f.data[i]);
      if (f.par_en) sample_bit(f.par_bit);
      if (f.stop2) sample_bit(f.stop0);
      check_eq("mid_frame", 32'(outs), 32'(5'b00001));
      last_stop = f.stop2 ? f.stop1 : f.stop0;
      sample_bit(last_stop);
      par_bad  = f.par_en && (f.par_bit != model_parity(f.typ, f.data));
      stop_bad = !f.stop0 || (f.stop2 && !f.stop1);
      exp_pdata = f.data;
      check_eq("result", 32'(outs), 32'({!par_bad && !stop_bad, par_bad, stop_bad, 2'b00}));
      check_eq("pdata", 32'(P_Data), 32'(exp_pdata));
      if (par_bad) exp_pcnt = sat_inc(exp_pcnt);
      if (stop_bad) exp_fcnt = sat_inc(exp_fcnt);
    end
    if (clr_at_end) begin
      clr_counts = 1'b1;
      exp_pcnt   = 0;
      exp_fcnt   = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    frame_t f;
    RST = 1'b0; frame_start = 1'b0; sample_valid = 1'b0; sampled_bit = 1'b0;
    PAR_EN = 1'b0; PAR_TYP = 2'b00; STOP2 = 1'b0; clr_counts = 1'b0;
    repeat (3) @(negedge CLK);
    check_eq("reset_outs", 32'(outs), 32'(5'b00000));
    check_eq("reset_pdata", 32'(P_Data), 32'(0));
    check_counts("reset");
    RST = 1'b1;
    idle(2);

    // Good even-parity frame, then the same frame with a bad parity bit.
    do_frame(mk(8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), 1'b0);
    do_frame(mk(8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1), 1'b0);
    idle(2);
    // Odd parity, two stops with the second low.
    do_frame(mk(8'h01, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0);
    idle(1);
    // Start glitch followed back-to-back by a good frame.
    do_frame(mk(8'h00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0);
    do_frame(mk(8'h5A, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), 1'b1);
    idle(1);

    // Saturation with a 2-bit counter, then clear racing a sixth error.
    for (int i = 0; i < 5; i++) begin
      do_frame(mk(8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1), 1'b0);
    end
    do_frame(mk(8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1), 1'b1);
    idle(1);
    check_counts("after_clr");
    // Build up nonzero counts so the reset below has something to clear.
    do_frame(mk(8'h11, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), 1'b0);
    idle(1);

    // Reset in the middle of the data bits.
    f = mk(8'hC3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    begin_frame(f);
    sample_bit(1'b0);
    for (int i = 0; i < 4; i++) sample_bit(f.data[i]);
    RST = 1'b0;
    @(negedge CLK);
    exp_pcnt = 0; exp_fcnt = 0; exp_pdata = '0;
    check_eq("midreset_outs", 32'(outs), 32'(5'b00000));
    check_eq("midreset_pdata", 32'(P_Data), 32'(0));
    check_counts("midreset");
    RST = 1'b1;
    idle(2);
    check_eq("post_reset_idle", 32'(outs), 32'(5'b00000));
    do_frame(mk(8'h3C, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), 1'b0);
    idle(2);
    check_counts("post_reset");

    for (int n = 0; n < 200; n++) begin
      do_frame(rand_frame(), ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 3));
    end
    idle(3);
    check_eq("final_outs", 32'(outs), 32'(5'b00000));
    check_counts("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_frame_check.md
RX_FRAME_CHECK -- requirements
Module: rx_frame_check

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter CNT_WIDTH, default 8, width of each saturating error counter; legal range 2..16.
REQ-003 CLK  in  1  single clock, all state on rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-low.
REQ-005 frame_start  in  1  one-cycle pulse from edge detector on a falling line edge.
REQ-006 sample_valid  in  1  one-cycle pulse at each bit's decided sample point.
REQ-007 sampled_bit  in  1  sampled line value, qualified by sample_valid.
REQ-008 PAR_EN  in  1  1 = frame carries a parity bit.
REQ-009 PAR_TYP  in  2  parity mode: 00 even, 01 odd, 10 mark, 11 space.
REQ-010 STOP2  in  1  1 = two stop bits, 0 = one stop bit.
REQ-011 clr_counts  in  1  synchronous clear of both error counters.
REQ-012 P_Data  out  DATA_WIDTH  last received data word, LSB first on the line.
REQ-013 data_valid  out  1  one-cycle pulse for a good frame.
REQ-014 parity_error  out  1  one-cycle pulse for a parity mismatch.
REQ-015 stop_error  out  1  one-cycle pulse when any stop bit samples 0.
REQ-016 start_error  out  1  one-cycle pulse when the start bit samples 1 (glitch).
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 parity_err_cnt  out  CNT_WIDTH  saturating count of parity_error pulses.
REQ-019 frame_err_cnt  out  CNT_WIDTH  saturating count of stop_error or start_error pulses.

Function
REQ-020 FSM states: IDLE, START, DATA, PARITY, STOP; all outputs registered.
REQ-021 IDLE->START on frame_start; PAR_EN, PAR_TYP and STOP2 latch in that cycle, and mid-frame changes have no effect.
REQ-022 frame_start outside IDLE is ignored; sample_valid in IDLE is ignored; in IDLE, simultaneous frame_start and sample_valid leave START with the sample discarded.
REQ-023 START, first sample_valid: bit 0 -> DATA; bit 1 -> start_error pulse next cycle, frame_err_cnt increments, return to IDLE.
REQ-024 DATA: exactly DATA_WIDTH sample_valid pulses; each shifts in LSB-first and updates a running XOR.
REQ-025 After the last data bit: PARITY if latched PAR_EN=1, else STOP.
REQ-026 Expected parity bit: even = XOR of data; odd = inverted XOR; mark = 1; space = 0. One sample is taken, and a mismatch is held internally until frame end.
REQ-027 STOP: one sample, or two if latched STOP2=1. Any stop sample of 0 sets the stop flag, and all stop samples are still consumed.
REQ-028 The cycle after the final stop sample_valid: P_Data updates unconditionally; data_valid pulses only if neither the parity flag nor the stop flag is set; parity_error and stop_error pulse per their flags in that same cycle; FSM returns to IDLE.
REQ-029 Latency is exactly 1 CLK from the final stop sample_valid to data_valid or error pulses; pulses never exceed 1 cycle.
REQ-030 Counters increment by 1 per error pulse and saturate at 2^CNT_WIDTH-1 without wrapping; if both stop and parity errors occur, each counter increments once.
REQ-031 clr_counts has priority over a same-cycle increment: the counter reads 0 next cycle.
REQ-032 frame_start may arrive in the cycle data_valid is asserted, since the FSM is already in IDLE; back-to-back frames are accepted with no gap.

Reset
REQ-033 On RST low: state IDLE; P_Data, data_valid, all error pulses, busy, both counters and all internal flags and latched config = 0.
REQ-034 Reset mid-frame aborts the frame: no pulse is issued and counters are not incremented after release.
REQ-035 After RST deasserts, the first frame_start is accepted normally.

Structure
REQ-036 Shared package uart_rx_pkg holds the FSM state enum and the PAR_TYP encodings (PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE).
REQ-037 One sub-module, sat_counter (parameter WIDTH; inputs inc, clr; output count), is instantiated twice.

Verification
REQ-038 DATA_WIDTH=8, even parity, one stop bit, data 0xA5, parity bit 0, stop 1 -> data_valid pulse, P_Data=0xA5, no errors.
REQ-039 Same frame with parity bit 1 -> parity_error pulse, no data_valid, P_Data=0xA5, parity_err_cnt=1.
REQ-040 Odd parity, data 0x01, parity 0, STOP2=1 with stops 1 then 0 -> stop_error only, frame_err_cnt=1, both stop samples consumed before IDLE.
REQ-041 frame_start then start sample 1 -> start_error pulse, busy drops next cycle, frame_err_cnt increments, and a following valid frame is received correctly.
REQ-042 CNT_WIDTH=2, five parity-error frames -> parity_err_cnt=3; clr_counts asserted in the same cycle as a sixth error -> count reads 0.
REQ-043 RST low after 4 data bits, then released, then a full 0x3C frame -> only that frame's data_valid, P_Data=0x3C, counters 0.
